rect_fill_engine: RTL and testbench

RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

---
 rtl/rect_fill_engine.sv | 161 ++++++++++++++++
 tb/tb_rect_fill_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: scans an inclusive corner box column-fastest, issuing one pixel write per cycle.
// Optional RECT_FILL_CLIP_EN clips out-of-range corners; without it they are rejected with an err pulse.
module rect_fill_engine #(
   parameter int COLS = 240,
   parameter int ROWS = 320
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [7:0]  x0,
   input  logic [7:0]  x1,
   input  logic [8:0]  y0,
   input  logic [8:0]  y1,
   input  logic [15:0] color,
   output logic        memWe,
   output logic [16:0] memAddr,
   output logic [15:0] memData,
   input  logic        memStall,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // state | meaning
   // IDLE  | waiting for a command, cmdReady high
   // SETUP | computing rowBase for the first row
   // FILL  | one write per unstalled cycle, column-fastest
   // DONE  | one-cycle done (or err for a rejected command)
   typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} stateT;

   localparam logic [7:0]  X_LAST   = 8'(COLS - 1);
   localparam logic [8:0]  Y_LAST   = 9'(ROWS - 1);
   localparam logic [16:0] ROW_STEP = 17'(COLS);

   stateT       state, stateNext;
   logic [7:0]  xStart, xEnd, xCur;
   logic [8:0]  yStart, yEnd, yCur;
   logic [16:0] rowBase;
   logic [15:0] colorReg;
   logic        rejFlag;

   logic [7:0]  xLo, xHi, xHiEff;
   logic [8:0]  yLo, yHi, yHiEff;
   logic        cmdReject, cmdEmpty;
   logic        lastCol, lastRow;

   // Constant multiply by COLS expanded into shifted adds of y.
   function automatic logic [16:0] mulCols(input logic [8:0] y);
      logic [16:0] acc;
      acc = '0;
      for (int i = 0; i < 17; i++) begin
         if (ROW_STEP[i]) acc = acc + (17'(y) << i);
      end
      return acc;
   endfunction

   always_comb begin
      xLo = (x0 > x1) ? x1 : x0;
      xHi = (x0 > x1) ? x0 : x1;
      yLo = (y0 > y1) ? y1 : y0;
      yHi = (y0 > y1) ? y0 : y1;
`ifdef RECT_FILL_CLIP_EN
      cmdReject = 1'b0;
      cmdEmpty  = (xLo > X_LAST) || (yLo > Y_LAST);
      xHiEff    = (xHi > X_LAST) ? X_LAST : xHi;
      yHiEff    = (yHi > Y_LAST) ? Y_LAST : yHi;
`else
      cmdReject = (x0 > X_LAST) || (x1 > X_LAST) || (y0 > Y_LAST) || (y1 > Y_LAST);
      cmdEmpty  = 1'b0;
      xHiEff    = xHi;
      yHiEff    = yHi;
`endif
   end

   assign lastCol = (xCur == xEnd);
   assign lastRow = (yCur == yEnd);

   always_ff @(posedge CLK_I) begin
      if (RST_I) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      cmdReady  = 1'b0;
      memWe     = 1'b0;
      memAddr   = '0;
      memData   = '0;
      busy      = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            cmdReady = 1'b1;
            busy     = 1'b0;
            if (cmdValid) stateNext = (cmdReject || cmdEmpty) ? DONE : SETUP;
         end
         SETUP: stateNext = FILL;
         FILL: begin
            memWe   = 1'b1;
            memAddr = rowBase + 17'(xCur);
            memData = colorReg;
            if (!memStall && lastCol && lastRow) stateNext = DONE;
         end
         DONE: begin
            done      = !rejFlag;
            err       = rejFlag;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         xStart   <= '0;
         xEnd     <= '0;
         xCur     <= '0;
         yStart   <= '0;
         yEnd     <= '0;
         yCur     <= '0;
         rowBase  <= '0;
         colorReg <= '0;
         rejFlag  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmdValid) begin
                  xStart   <= xLo;
                  xEnd     <= xHiEff;
                  yStart   <= yLo;
                  yEnd     <= yHiEff;
                  colorReg <= color;
                  rejFlag  <= cmdReject;
               end
            end
            SETUP: begin
               rowBase <= mulCols(yStart);
               xCur    <= xStart;
               yCur    <= yStart;
            end
            FILL: begin
               if (!memStall) begin
                  if (lastCol) begin
                     xCur <= xStart;
                     if (!lastRow) begin
                        yCur    <= yCur + 9'd1;
                        rowBase <= rowBase + ROW_STEP;
                     end
                  end else begin
                     xCur <= xCur + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine against a list-of-addresses reference model.
// Expectations for out-of-range corners follow RECT_FILL_CLIP_EN when it is defined.
module tb_rect_fill_engine;
   localparam int C = 240;
   localparam int R = 320;

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b1;
   logic        cmdValid = 1'b0;
   logic        cmdReady;
   logic [7:0]  x0 = '0, x1 = '0;
   logic [8:0]  y0 = '0, y1 = '0;
   logic [15:0] color = '0;
   logic        memWe;
   logic [16:0] memAddr;
   logic [15:0] memData;
   logic        memStall = 1'b0;
   logic        busy, done, err;

   rect_fill_engine #(.COLS(C), .ROWS(R)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .cmdValid(cmdValid), .cmdReady(cmdReady),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
      .memWe(memWe), .memAddr(memAddr), .memData(memData), .memStall(memStall),
      .busy(busy), .done(done), .err(err)
   );

   always #5 CLK_I = ~CLK_I;

   int total = 0;
   int bad = 0;

   int expAddr[$];
   bit expErr;
   int obsAddr[$];
   int obsData[$];
   int doneCnt, errCnt, firstWeCyc, lastWrCyc, doneCyc, errCyc, holdCnt, strayCnt;
   bit timedOut;
   int stallAt = -1;
   int stallLen = 0;

   // Reference: every pixel of the ordered (and optionally clipped) box, row by row.
   function automatic void model_rect(input int ax0, input int ay0, input int ax1, input int ay1);
      int xs, xe, ys, ye;
      expAddr.delete();
      expErr = 1'b0;
      xs = (ax0 < ax1) ? ax0 : ax1;
      xe = (ax0 < ax1) ? ax1 : ax0;
      ys = (ay0 < ay1) ? ay0 : ay1;
      ye = (ay0 < ay1) ? ay1 : ay0;
`ifdef RECT_FILL_CLIP_EN
      if (xe > C - 1) xe = C - 1;
      if (ye > R - 1) ye = R - 1;
      if (xs > C - 1 || ys > R - 1) return;
`else
      if (xe > C - 1 || ye > R - 1) begin
         expErr = 1'b1;
         return;
      end
`endif
      for (int y = ys; y <= ye; y++)
         for (int x = xs; x <= xe; x++)
            expAddr.push_back(y * C + x);
   endfunction

   // Issues one command and records every completed write until the engine is idle again.
   task automatic do_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                         input logic [15:0] col, input int stallPct, input bit junk, input int budget);
      int cyc;
      int stallRun;
      bit st;
      bit seenIdle;
      obsAddr.delete();
      obsData.delete();
      doneCnt = 0; errCnt = 0; firstWeCyc = -1; lastWrCyc = -1; doneCyc = -1; errCyc = -1;
      holdCnt = 0; strayCnt = 0; timedOut = 1'b0; stallRun = 0;
      @(negedge CLK_I);
      x0 = ax0[7:0]; y0 = ay0[8:0]; x1 = ax1[7:0]; y1 = ay1[8:0];
      color = col;
      cmdValid = 1'b1;
      memStall = 1'b0;
      @(negedge CLK_I);
      cyc = 1;
      seenIdle = 1'b0;
      while (!seenIdle) begin
         if (cyc > budget) begin
            timedOut = 1'b1;
            break;
         end
         st = 1'b0;
         if (memWe) begin
            if (firstWeCyc < 0) firstWeCyc = cyc;
            if (stallAt >= 0 && int'(memAddr) == stallAt) begin
               holdCnt++;
               if (stallRun < stallLen) begin
                  st = 1'b1;
                  stallRun++;
               end
            end else if (int'($urandom_range(99, 0)) < stallPct) begin
               st = 1'b1;
            end
            if (!st) begin
               obsAddr.push_back(int'(memAddr));
               obsData.push_back(int'(memData));
               lastWrCyc = cyc;
            end
         end
         if (done) begin doneCnt++; doneCyc = cyc; end
         if (err)  begin errCnt++;  errCyc = cyc;  end
         memStall = st;
         if (cmdReady) seenIdle = 1'b1;
         if (junk && !cmdReady) begin
            cmdValid = 1'b1;
            x0 = 8'($urandom); x1 = 8'($urandom);
            y0 = 9'($urandom); y1 = 9'($urandom);
            color = 16'($urandom);
         end else begin
            cmdValid = 1'b0;
         end
         @(negedge CLK_I);
         cyc++;
      end
      memStall = 1'b0;
      cmdValid = 1'b0;
      repeat (2) begin
         if (memWe || done || err) strayCnt++;
         @(negedge CLK_I);
      end
   endtask

   task automatic test_reset();
      RST_I = 1'b1;
      repeat (3) @(posedge CLK_I);
      @(negedge CLK_I);
      total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL reset_cmdReady got=%0b want=1", cmdReady); end
      total++; if (memWe !== 1'b0) begin bad++; $display("FAIL reset_memWe got=%0b want=0", memWe); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%0b%0b want=00", done, err); end
      total++; if (memAddr !== 17'd0) begin bad++; $display("FAIL reset_memAddr got=%0d want=0", memAddr); end
      total++; if (memData !== 16'd0) begin bad++; $display("FAIL reset_memData got=%0h want=0", memData); end
      RST_I = 1'b0;
      @(negedge CLK_I);
      total++; if (cmdReady !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_release got=%0b/%0b want=1/0", cmdReady, busy); end
   endtask

   task automatic test_basic();
      int fixedList[6] = '{1210, 1211, 1212, 1450, 1451, 1452};
      int nBad;
      model_rect(10, 5, 12, 6);
      do_cmd(10, 5, 12, 6, 16'hF800, 0, 1'b0, 100);
      total++; if (timedOut) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
      total++; if (obsAddr.size() != 6) begin bad++; $display("FAIL basic_count got=%0d want=6", obsAddr.size()); end
      nBad = 0;
      for (int i = 0; i < 6; i++)
         if (i >= obsAddr.size() || obsAddr[i] != fixedList[i] || obsAddr[i] != expAddr[i] || obsData[i] != 16'hF800) nBad++;
      total++; if (nBad != 0) begin bad++; $display("FAIL basic_addr_data got=%0d wrong want=0", nBad); end
      total++; if (doneCnt != 1 || errCnt != 0) begin bad++; $display("FAIL basic_done got=%0d/%0d want=1/0", doneCnt, errCnt); end
      total++; if (doneCyc != lastWrCyc + 1) begin bad++; $display("FAIL basic_done_time got=%0d want=%0d", doneCyc, lastWrCyc + 1); end
      total++; if (strayCnt != 0) begin bad++; $display("FAIL basic_stray got=%0d want=0", strayCnt); end
   endtask

   task automatic test_swap();
      do_cmd(3, 0, 1, 0, 16'h07E0, 0, 1'b0, 100);
      total++; if (obsAddr.size() != 3) begin bad++; $display("FAIL swap_count got=%0d want=3", obsAddr.size()); end
      else begin
         total++; if (obsAddr[0] != 1 || obsAddr[1] != 2 || obsAddr[2] != 3) begin
            bad++; $display("FAIL swap_addr got=%0d,%0d,%0d want=1,2,3", obsAddr[0], obsAddr[1], obsAddr[2]); end
      end
      total++; if (firstWeCyc != 2) begin bad++; $display("FAIL swap_latency got=%0d want=2", firstWeCyc); end
   endtask

   task automatic test_stall();
      int nBad;
      model_rect(18, 2, 22, 2);
      stallAt = 500;
      stallLen = 3;
      do_cmd(18, 2, 22, 2, 16'h1234, 0, 1'b0, 100);
      stallAt = -1;
      total++; if (holdCnt != 4) begin bad++; $display("FAIL stall_hold got=%0d want=4", holdCnt); end
      total++; if (obsAddr.size() != 5) begin bad++; $display("FAIL stall_count got=%0d want=5", obsAddr.size()); end
      nBad = 0;
      for (int i = 0; i < expAddr.size(); i++)
         if (i >= obsAddr.size() || obsAddr[i] != expAddr[i] || obsData[i] != 16'h1234) nBad++;
      total++; if (nBad != 0) begin bad++; $display("FAIL stall_addr got=%0d wrong want=0", nBad); end
   endtask

   task automatic test_clip();
      do_cmd(230, 0, 250, 0, 16'hABCD, 0, 1'b0, 100);
`ifdef RECT_FILL_CLIP_EN
      total++; if (obsAddr.size() != 10) begin bad++; $display("FAIL clip_count got=%0d want=10", obsAddr.size()); end
      else begin
         total++; if (obsAddr[0] != 230 || obsAddr[9] != 239) begin
            bad++; $display("FAIL clip_addr got=%0d..%0d want=230..239", obsAddr[0], obsAddr[9]); end
      end
      total++; if (doneCnt != 1 || errCnt != 0) begin bad++; $display("FAIL clip_done got=%0d/%0d want=1/0", doneCnt, errCnt); end
`else
      total++; if (obsAddr.size() != 0 || firstWeCyc != -1) begin bad++; $display("FAIL reject_writes got=%0d want=0", obsAddr.size()); end
      total++; if (errCnt != 1 || doneCnt != 0) begin bad++; $display("FAIL reject_err got=%0d/%0d want=1/0", errCnt, doneCnt); end
      total++; if (errCyc != 1) begin bad++; $display("FAIL reject_err_time got=%0d want=1", errCyc); end
`endif
   endtask

   task automatic test_random();
      int ax0, ax1, ay0, ay1, nBad;
      logic [15:0] col;
      for (int n = 0; n < 16; n++) begin
         if (n % 2 == 0) begin
            ax0 = $urandom_range(C - 1, 0);
            ay0 = $urandom_range(R - 1, 0);
            ax1 = ax0 + $urandom_range(10, 0) - 5;
            ay1 = ay0 + $urandom_range(6, 0) - 3;
            if (ax1 < 0) ax1 = 0;
            if (ax1 > C - 1) ax1 = C - 1;
            if (ay1 < 0) ay1 = 0;
            if (ay1 > R - 1) ay1 = R - 1;
         end else begin
            ax0 = $urandom_range(255, 228);
            ay0 = $urandom_range(511, 312);
            ax1 = ax0 + $urandom_range(10, 0) - 5;
            ay1 = ay0 + $urandom_range(6, 0) - 3;
            if (ax1 > 255) ax1 = 255;
            if (ay1 > 511) ay1 = 511;
         end
         col = 16'($urandom);
         model_rect(ax0, ay0, ax1, ay1);
         do_cmd(ax0, ay0, ax1, ay1, col, 30, 1'b1, 1000);
         total++; if (timedOut) begin bad++; $display("FAIL rand%0d_timeout got=1 want=0", n); end
         total++; if (obsAddr.size() != expAddr.size()) begin
            bad++; $display("FAIL rand%0d_count got=%0d want=%0d", n, obsAddr.size(), expAddr.size()); end
         nBad = 0;
         for (int i = 0; i < expAddr.size(); i++)
            if (i >= obsAddr.size() || obsAddr[i] != expAddr[i] || obsData[i] != int'(col)) nBad++;
         total++; if (nBad != 0) begin bad++; $display("FAIL rand%0d_addr_data got=%0d wrong want=0", n, nBad); end
         total++; if (doneCnt != (expErr ? 0 : 1) || errCnt != (expErr ? 1 : 0)) begin
            bad++; $display("FAIL rand%0d_done_err got=%0d/%0d want=%0d/%0d", n, doneCnt, errCnt, !expErr, expErr); end
         total++; if (strayCnt != 0) begin bad++; $display("FAIL rand%0d_stray got=%0d want=0", n, strayCnt); end
      end
   endtask

   task automatic test_full();
      int nBad;
      model_rect(0, 0, C - 1, R - 1);
      do_cmd(0, 0, C - 1, R - 1, 16'h5A5A, 0, 1'b0, 80000);
      total++; if (obsAddr.size() != C * R) begin bad++; $display("FAIL full_count got=%0d want=%0d", obsAddr.size(), C * R); end
      nBad = 0;
      for (int i = 0; i < C * R; i++)
         if (i >= obsAddr.size() || obsAddr[i] != i) nBad++;
      total++; if (nBad != 0) begin bad++; $display("FAIL full_order got=%0d wrong want=0", nBad); end
      total++; if (obsAddr.size() == 0 || obsAddr[obsAddr.size() - 1] != 76799) begin
         bad++; $display("FAIL full_last got=%0d want=76799", (obsAddr.size() == 0) ? -1 : obsAddr[obsAddr.size() - 1]); end
      total++; if (lastWrCyc - firstWeCyc + 1 != C * R) begin
         bad++; $display("FAIL full_consecutive got=%0d want=%0d", lastWrCyc - firstWeCyc + 1, C * R); end
      total++; if (doneCnt != 1 || doneCyc != lastWrCyc + 1) begin
         bad++; $display("FAIL full_done got=%0d@%0d want=1@%0d", doneCnt, doneCyc, lastWrCyc + 1); end
   endtask

   task automatic test_reset_mid();
      int wr, seen;
      @(negedge CLK_I);
      x0 = 8'd0; x1 = 8'd9; y0 = 9'd0; y1 = 9'd9; color = 16'hFFFF;
      cmdValid = 1'b1;
      @(negedge CLK_I);
      cmdValid = 1'b0;
      wr = 0;
      for (int c = 0; c < 50 && wr < 4; c++) begin
         if (memWe) wr++;
         if (wr < 4) @(negedge CLK_I);
      end
      total++; if (wr != 4) begin bad++; $display("FAIL rstmid_reach got=%0d want=4", wr); end
      @(posedge CLK_I);
      #1 RST_I = 1'b1;
      @(posedge CLK_I);
      @(negedge CLK_I);
      total++; if (memWe !== 1'b0) begin bad++; $display("FAIL rstmid_memWe got=%0b want=0", memWe); end
      RST_I = 1'b0;
      seen = 0;
      repeat (5) begin
         if (done || err || memWe) seen++;
         @(negedge CLK_I);
      end
      total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", seen); end
      total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b want=1", cmdReady); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_swap();
      test_stall();
      test_clip();
      test_random();
      test_reset_mid();
      test_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
